// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and ROB owner tag.
// Commits release ownership only on tag match and are bypassed to same-cycle reads.
module regfile_tagged #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned TAGW = 4,
    parameter int unsigned NRD  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_rd,
    input  logic [TAGW-1:0]      issue_tag,
    input  logic                 commit_en,
    input  logic [AW-1:0]        commit_rd,
    input  logic [TAGW-1:0]      commit_tag,
    input  logic [XLEN-1:0]      commit_data,
    input  logic                 flush,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*TAGW-1:0]  rd_tag
);

    logic [XLEN-1:0] data_q [NREG];
    logic [TAGW-1:0] tag_q  [NREG];
    logic [NREG-1:0] busy_q;

    logic commit_ok;
    logic commit_hit;
    logic issue_ok;

    assign commit_ok  = commit_en && (commit_rd != '0);
    assign commit_hit = commit_ok && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);
    assign issue_ok   = issue_en && (issue_rd != '0);

    // Later assignments win: flush overrides issue, issue overrides a commit release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
        end else begin
            if (commit_ok) begin
                data_q[commit_rd] <= commit_data;
                if (commit_hit) begin
                    busy_q[commit_rd] <= 1'b0;
                    tag_q[commit_rd]  <= '0;
                end
            end
            if (flush) begin
                busy_q <= '0;
                for (int unsigned r = 0; r < NREG; r++) begin
                    tag_q[r] <= '0;
                end
            end else if (issue_ok) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_tag;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        if (rst) begin
            for (int unsigned i = 0; i < NRD; i++) begin
                a = rd_addr[i*AW +: AW];
                if (a != '0) begin
                    if (commit_hit && (commit_rd == a)) begin
                        rd_data[i*XLEN +: XLEN] = commit_data;
                    end else begin
                        rd_data[i*XLEN +: XLEN] = data_q[a];
                        if (busy_q[a]) begin
                            rd_busy[i]              = 1'b1;
                            rd_tag[i*TAGW +: TAGW]  = tag_q[a];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// Randomised and directed bench for regfile_tagged (XLEN=64, NREG=16, NRD=4)
// against an array-based model of the register/ownership rules.
module tb_regfile_tagged;

    localparam int XLEN = 64;
    localparam int NREG = 16;
    localparam int TAGW = 4;
    localparam int NRD  = 4;
    localparam int AW   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 issue_en = 1'b0;
    logic [AW-1:0]        issue_rd = '0;
    logic [TAGW-1:0]      issue_tag = '0;
    logic                 commit_en = 1'b0;
    logic [AW-1:0]        commit_rd = '0;
    logic [TAGW-1:0]      commit_tag = '0;
    logic [XLEN-1:0]      commit_data = '0;
    logic                 flush = 1'b0;
    logic [NRD*AW-1:0]    rd_addr = '0;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*TAGW-1:0]  rd_tag;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] m_data [NREG];
    bit              m_busy [NREG];
    logic [TAGW-1:0] m_tag  [NREG];

    regfile_tagged #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .commit_data(commit_data), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        issue_en = 1'b0; commit_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic do_issue(input int r, input int t);
        issue_en = 1'b1; issue_rd = AW'(r); issue_tag = TAGW'(t);
    endtask

    task automatic do_commit(input int r, input int t, input logic [63:0] d);
        commit_en = 1'b1; commit_rd = AW'(r); commit_tag = TAGW'(t); commit_data = d;
    endtask

    // Expected read-port view from the model and the current inputs.
    task automatic check_reads();
        for (int p = 0; p < NRD; p++) begin
            int a;
            logic [63:0] ed;
            logic eb;
            logic [3:0] et;
            a = int'(rd_addr[p*AW +: AW]);
            ed = '0; eb = 1'b0; et = '0;
            if (rst && a != 0) begin
                if (commit_en && int'(commit_rd) == a && m_busy[a] && m_tag[a] == commit_tag) begin
                    ed = commit_data;
                end else begin
                    ed = m_data[a];
                    if (m_busy[a]) begin
                        eb = 1'b1; et = m_tag[a];
                    end
                end
            end
            check_eq($sformatf("p%0d_data_x%0d", p, a), rd_data[p*XLEN +: XLEN], ed);
            check_eq($sformatf("p%0d_busy_x%0d", p, a), 64'(rd_busy[p]), 64'(eb));
            check_eq($sformatf("p%0d_tag_x%0d", p, a), 64'(rd_tag[p*TAGW +: TAGW]), 64'(et));
        end
    endtask

    task automatic model_update();
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
        end else begin
            if (commit_en && commit_rd != 0) begin
                m_data[commit_rd] = commit_data;
                if (m_busy[commit_rd] && m_tag[commit_rd] == commit_tag) begin
                    m_busy[commit_rd] = 1'b0; m_tag[commit_rd] = '0;
                end
            end
            if (flush) begin
                for (int r = 0; r < NREG; r++) begin
                    m_busy[r] = 1'b0; m_tag[r] = '0;
                end
            end else if (issue_en && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1; m_tag[issue_rd] = issue_tag;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_reads();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end

        // Reset, then sweep all registers on all ports.
        rst = 1'b0; idle();
        cycle();
        cycle();
        rst = 1'b1;
        for (int b = 0; b < NREG; b += NRD) begin
            for (int p = 0; p < NRD; p++) set_rd(p, b + p);
            cycle();
        end

        // x0 ignores issue.
        do_issue(0, 3); set_rd(0, 0);
        cycle(); idle();
        sample(); check_eq("x0_busy", 64'(rd_busy[0]), 64'd0); advance();

        // Issue x5 tag 7, then matching commit with same-cycle bypass.
        do_issue(5, 7); set_rd(0, 5);
        cycle(); idle();
        sample();
        check_eq("x5_busy", 64'(rd_busy[0]), 64'd1);
        check_eq("x5_tag", 64'(rd_tag[3:0]), 64'd7);
        advance();
        do_commit(5, 7, 64'hDEADBEEF);
        sample();
        check_eq("x5_byp_data", rd_data[63:0], 64'hDEADBEEF);
        check_eq("x5_byp_busy", 64'(rd_busy[0]), 64'd0);
        advance(); idle();
        sample();
        check_eq("x5_after_data", rd_data[63:0], 64'hDEADBEEF);
        check_eq("x5_after_busy", 64'(rd_busy[0]), 64'd0);
        advance();

        // Stale commit keeps the newer owner.
        do_issue(5, 2); cycle();
        do_issue(5, 9); cycle(); idle();
        do_commit(5, 2, 64'h11); cycle(); idle();
        sample();
        check_eq("stale_data", rd_data[63:0], 64'h11);
        check_eq("stale_busy", 64'(rd_busy[0]), 64'd1);
        check_eq("stale_tag", 64'(rd_tag[3:0]), 64'd9);
        advance();
        do_commit(5, 9, 64'h22); cycle(); idle();
        sample();
        check_eq("own_data", rd_data[63:0], 64'h22);
        check_eq("own_busy", 64'(rd_busy[0]), 64'd0);
        advance();

        // Issue and matching commit to the same register in one cycle.
        do_issue(8, 1); set_rd(1, 8); cycle();
        do_issue(8, 4); do_commit(8, 1, 64'hAB);
        sample();
        check_eq("ic_byp_data", rd_data[127:64], 64'hAB);
        check_eq("ic_byp_busy", 64'(rd_busy[1]), 64'd0);
        advance(); idle();
        sample();
        check_eq("ic_next_busy", 64'(rd_busy[1]), 64'd1);
        check_eq("ic_next_tag", 64'(rd_tag[7:4]), 64'd4);
        check_eq("ic_next_data", rd_data[127:64], 64'hAB);
        advance();

        // Flush drops a same-cycle issue but keeps commit data.
        do_issue(3, 1); cycle();
        do_issue(4, 2); cycle();
        do_issue(6, 3); cycle();
        flush = 1'b1; do_issue(7, 5); do_commit(4, 0, 64'h55);
        cycle(); idle();
        set_rd(0, 3); set_rd(1, 4); set_rd(2, 6); set_rd(3, 7);
        sample();
        check_eq("fl_busy_all", 64'(rd_busy), 64'd0);
        check_eq("fl_x4_data", rd_data[127:64], 64'h55);
        advance();

        // Aliased and distinct ports during a matching commit.
        do_issue(9, 5); cycle(); idle();
        do_issue(10, 6); cycle(); idle();
        do_commit(9, 5, 64'h0123_4567_89AB_CDEF);
        set_rd(0, 9); set_rd(1, 9); set_rd(2, 10); set_rd(3, 9);
        cycle(); idle();

        // Reset mid-operation discards pending ownership.
        do_issue(11, 8); cycle(); idle();
        rst = 1'b0; set_rd(0, 11); set_rd(1, 10);
        cycle();
        rst = 1'b1;
        sample();
        check_eq("rst_mid_busy", 64'(rd_busy), 64'd0);
        check_eq("rst_mid_data", rd_data[127:64], 64'd0);
        advance();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            issue_en  = $urandom_range(1);
            issue_rd  = AW'($urandom_range(NREG - 1));
            issue_tag = TAGW'($urandom);
            commit_en = $urandom_range(1);
            commit_rd = AW'($urandom_range(NREG - 1));
            commit_tag = ($urandom_range(1) == 1) ? m_tag[commit_rd] : TAGW'($urandom);
            commit_data = {$urandom, $urandom};
            flush = ($urandom_range(15) == 0);
            rst = ($urandom_range(63) != 0);
            for (int p = 0; p < NRD; p++) begin
                set_rd(p, ($urandom_range(3) == 0) ? int'(commit_rd) : int'($urandom_range(NREG - 1)));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file for the out-of-order core. It pairs each register with a busy bit and a reorder-buffer tag so that decode and issue can resolve operands against a pending producer. Decode reads operands and marks destinations busy. Commit writes results back and releases the busy bit only when the committing tag matches the register's current owner. A flush clears all pending ownership on mispredict.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of registers (power of two, ≥2); AW = $clog2(NREG)
- TAGW, 4, ROB tag width
- NRD, 2, number of read ports

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- issue_en  in  1  claim a destination register this cycle
- issue_rd  in  AW  destination register index
- issue_tag  in  TAGW  ROB tag of the new producer
- commit_en  in  1  write back a committed result
- commit_rd  in  AW  committed register index
- commit_tag  in  TAGW  ROB tag of the committing instruction
- commit_data  in  XLEN  committed value
- flush  in  1  clear all busy bits (mispredict recovery)
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  register values; port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  1 = value pending; rd_tag names the producer
- rd_tag  out  NRD*TAGW  producer tag, valid when rd_busy[i]=1, else 0

## Operation
- Storage:
  - data[NREG], busy[NREG] and tag[NREG] are flops updated on posedge clk.
  - Read outputs are combinational.
- Reset (rst=0 at posedge):
  - All data, busy and tag entries are cleared to 0.
  - While rst=0, all read outputs are forced to 0.
- Register 0:
  - Reads always return data=0, busy=0, tag=0.
  - Issue and commit to index 0 are ignored.
- Commit:
  - data[commit_rd] ← commit_data unconditionally.
  - busy[commit_rd] is cleared only if busy=1 and tag[commit_rd]==commit_tag. A stale commit (tag mismatch) writes data but leaves busy and tag intact.
- Issue: busy[issue_rd] ← 1 and tag[issue_rd] ← issue_tag.
- Flush:
  - All busy and tag entries are cleared.
  - Commit data is still written in the same cycle.
  - A same-cycle issue is dropped.
- Priority on the same register in one cycle: flush > issue > commit-release. Issue plus commit to the same register leaves busy=1 with tag=issue_tag, and the data is still written.
- Read port i, for address a ≠ 0:
  - Bypass case: commit_en=1, commit_rd==a, busy[a]=1 and tag[a]==commit_tag. Outputs are rd_data=commit_data, rd_busy=0, rd_tag=0.
  - Pending case: otherwise, if busy[a]=1, outputs are rd_data=data[a], rd_busy=1, rd_tag=tag[a].
  - Idle case: otherwise, outputs are rd_data=data[a], rd_busy=0, rd_tag=0.
  - Reads never see a same-cycle issue or flush. An instruction reading its own destination as a source therefore sees the prior producer.
  - A stale commit is not bypassed.

## Timing
- Issue, commit and flush state changes become visible on the read ports one cycle after the posedge.
- A matching commit is bypassed in the same cycle (zero latency).
- No handshake: every request is accepted every cycle, with no stall output.
- Reset mid-operation discards all pending state. The first post-reset cycle reads zeros and not-busy.
- All NRD ports are independent and may alias the same address. They return identical results when aliased.

## Test plan
- Reset, then read all registers on every port → data=0, busy=0, tag=0. Issue to x0 with tag 3 → x0 still reads 0 and not busy.
- Issue x5 with tag 7; next cycle read x5 → busy=1, tag=7. Commit x5 with tag 7 and data 0xDEADBEEF; the same-cycle read gives data=0xDEADBEEF, busy=0, and the next cycle reads the same.
- Issue x5 tag 2, then issue x5 tag 9, then commit x5 tag 2 with data 0x11 → data=0x11 but still busy, tag=9. Commit tag 9 with data 0x22 → data 0x22, busy=0.
- Same cycle: issue x8 tag 4, commit x8 tag 1 (owner tag 1), read x8 → the read shows the bypassed commit value, not busy. Next cycle: busy=1, tag=4, data=commit value.
- Issue x3, x4, x6; assert flush together with issue x7 and commit x4 data 0x55 → next cycle all not busy, x7 not busy, x4=0x55.
- NRD=4, XLEN=64, NREG=16: all four ports read distinct and aliased addresses during a commit → per-port results match the rules above.
